// File: rtl/cpu_pkg.sv
// Shared CPU-core constants and types used by the thread arbiters.
package cpu_pkg;

  localparam int THREAD_W        = 2;
  localparam int NTHREADS        = 4;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set request after the last winner.
module rr_pick4
  import cpu_pkg::*;
(
  input  logic [NTHREADS-1:0] req,
  input  logic [THREAD_W-1:0] last,
  output logic [THREAD_W-1:0] grant,
  output logic                valid
);

  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = NTHREADS; k >= 1; k--) begin
      if (req[last + THREAD_W'(k)]) begin
        grant = last + THREAD_W'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_thread_arbiter.sv
// Shares the single FETCH port among four hardware threads, round-robin,
// with a watchdog that aborts transfers FETCH never acknowledges.
module fetch_thread_arbiter #(
  parameter int NTHREADS = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TIMEOUT  = cpu_pkg::TIMEOUT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NTHREADS-1:0]            t_req,
  input  logic [NTHREADS-1:0]            t_write,
  input  logic [NTHREADS*AW-1:0]         t_addr,
  input  logic [NTHREADS*DW-1:0]         t_wdata,
  output logic [NTHREADS-1:0]            t_ack,
  output logic                           t_err,
  output logic [DW-1:0]                  t_rdata,
  output logic                           f_enable,
  output logic                           f_write,
  output logic [AW-1:0]                  f_addr,
  output logic [DW-1:0]                  f_wdata,
  output logic [cpu_pkg::THREAD_W-1:0]   f_thread,
  input  logic [DW-1:0]                  f_rdata,
  input  logic                           f_ack
);
  import cpu_pkg::*;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t              state;
  logic [THREAD_W-1:0] last;
  logic [THREAD_W-1:0] gnt;
  logic                gnt_vld;
  logic [CW-1:0]       cnt;

  rr_pick4 u_pick (
    .req   (t_req),
    .last  (last),
    .grant (gnt),
    .valid (gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last     <= THREAD_W'(3);
      cnt      <= '0;
      f_enable <= 1'b0;
      f_write  <= 1'b0;
      f_addr   <= '0;
      f_wdata  <= '0;
      f_thread <= '0;
      t_ack    <= '0;
      t_err    <= 1'b0;
      t_rdata  <= '0;
    end else begin
      // Completion pulse lives only for the single DONE cycle.
      t_ack <= '0;
      t_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            f_thread <= gnt;
            f_addr   <= t_addr[int'(gnt)*AW +: AW];
            f_wdata  <= t_wdata[int'(gnt)*DW +: DW];
            f_write  <= t_write[gnt];
            f_enable <= 1'b1;
            cnt      <= '0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // An ack on the final watchdog cycle still counts as a clean completion.
          if (f_ack) begin
            t_rdata  <= f_write ? '0 : f_rdata;
            t_ack    <= NTHREADS'(1) << f_thread;
            f_enable <= 1'b0;
            last     <= f_thread;
            state    <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            t_rdata  <= '0;
            t_ack    <= NTHREADS'(1) << f_thread;
            t_err    <= 1'b1;
            f_enable <= 1'b0;
            last     <= f_thread;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_thread_arbiter.sv
// Bench for fetch_thread_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference of the round-robin sharing rules.
module tb_fetch_thread_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    t_req, t_write, t_ack;
  logic [4*AW-1:0] t_addr;
  logic [4*DW-1:0] t_wdata;
  logic          t_err;
  logic [DW-1:0] t_rdata;
  logic          f_enable, f_write, f_ack;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_wdata, f_rdata;
  logic [1:0]    f_thread;

  logic [AW-1:0] addr [4];
  logic [DW-1:0] wdat [4];

  int n_vec = 0;
  int n_err = 0;

  always_comb begin
    t_addr  = '0;
    t_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      t_addr[i*AW +: AW]  = addr[i];
      t_wdata[i*DW +: DW] = wdat[i];
    end
  end

  fetch_thread_arbiter #(.NTHREADS(4), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .t_req(t_req), .t_write(t_write), .t_addr(t_addr), .t_wdata(t_wdata),
    .t_ack(t_ack), .t_err(t_err), .t_rdata(t_rdata),
    .f_enable(f_enable), .f_write(f_write), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_thread(f_thread), .f_rdata(f_rdata), .f_ack(f_ack)
  );

  always #5 clk = ~clk;

  function automatic int pick(int last, logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; t_req = '0; t_write = '0; f_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; t_req = 4'b1111; t_write = '0; f_ack = 1'b0; f_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = 32'h1000 + 32'(i) * 32'h10;
      wdat[i] = 32'hA0 + 32'(i);
    end
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if ({f_enable, f_write, f_addr, f_wdata, f_thread, t_ack, t_err, t_rdata} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: en=%b wr=%b addr=%h wd=%h thr=%0d ack=%b err=%b rd=%h, expected all 0",
                 f_enable, f_write, f_addr, f_wdata, f_thread, t_ack, t_err, t_rdata);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (f_enable !== 1'b1 || f_thread !== 2'd0 || f_addr !== 32'h1000) begin
      n_err++;
      $display("FAIL reset_first_grant: en=%b thr=%0d addr=%h, expected en=1 thr=0 addr=00001000",
               f_enable, f_thread, f_addr);
    end
    f_ack = 1'b1;
    @(negedge clk);
    n_vec++;
    if (t_ack !== 4'b0001) begin
      n_err++; $display("FAIL reset_first_ack: t_ack=%b expected 0001", t_ack);
    end
    t_req = '0; f_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    addr[2] = 32'h100; t_write = '0; t_req = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (f_enable !== 1'b1 || f_thread !== 2'd2 || f_addr !== 32'h100) begin
        n_err++;
        $display("FAIL read_busy_%0d: en=%b thr=%0d addr=%h, expected en=1 thr=2 addr=00000100",
                 k, f_enable, f_thread, f_addr);
      end
      if (k == 4) begin f_ack = 1'b1; f_rdata = 32'hDEADBEEF; end
    end
    @(negedge clk);
    n_vec++;
    if (f_enable !== 1'b0 || t_ack !== 4'b0100 || t_rdata !== 32'hDEADBEEF || t_err !== 1'b0) begin
      n_err++;
      $display("FAIL read_ack: en=%b ack=%b rd=%h err=%b, expected en=0 ack=0100 rd=deadbeef err=0",
               f_enable, t_ack, t_rdata, t_err);
    end
    f_ack = 1'b0; t_req = '0;
    @(negedge clk);
    n_vec++;
    if (t_ack !== 4'b0000) begin
      n_err++; $display("FAIL read_ack_width: t_ack=%b expected 0000", t_ack);
    end
  endtask

  task automatic test_round_robin();
    int got;
    int cyc;
    got = 0; cyc = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) addr[i] = 32'h4000 + 32'(i);
    t_req = 4'b1111;
    while (got < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (t_ack !== 4'b0000) begin
        n_vec++;
        if (t_ack !== (4'b0001 << (got % 4))) begin
          n_err++; $display("FAIL rr_order_%0d: t_ack=%b expected %b", got, t_ack, 4'b0001 << (got % 4));
        end
        got++;
      end
      if (f_enable === 1'b1) begin
        n_vec++;
        if (f_thread !== 2'(got % 4) || f_addr !== addr[got % 4]) begin
          n_err++;
          $display("FAIL rr_grant_%0d: thr=%0d addr=%h expected thr=%0d addr=%h",
                   got, f_thread, f_addr, got % 4, addr[got % 4]);
        end
      end
      f_ack = f_enable;
    end
    n_vec++;
    if (got != 5) begin
      n_err++; $display("FAIL rr_budget: acks=%0d expected 5 within 60 cycles", got);
    end
    t_req = '0; f_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    apply_reset();
    addr[1] = 32'h200; wdat[1] = 32'h12345678; f_rdata = 32'h5A5A5A5A;
    t_write = 4'b0010; t_req = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (f_enable !== 1'b1 || f_write !== 1'b1 || f_wdata !== 32'h12345678 || f_thread !== 2'd1) begin
        n_err++;
        $display("FAIL write_busy_%0d: en=%b wr=%b wd=%h thr=%0d, expected en=1 wr=1 wd=12345678 thr=1",
                 k, f_enable, f_write, f_wdata, f_thread);
      end
      if (k == 3) f_ack = 1'b1;
    end
    @(negedge clk);
    n_vec++;
    if (t_ack !== 4'b0010 || t_rdata !== '0 || t_err !== 1'b0) begin
      n_err++;
      $display("FAIL write_ack: ack=%b rd=%h err=%b, expected ack=0010 rd=0 err=0", t_ack, t_rdata, t_err);
    end
    t_req = '0; t_write = '0; f_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    apply_reset();
    addr[3] = 32'h300; t_req = 4'b1001;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      n_vec++;
      if (f_enable !== 1'b1 || f_thread !== 2'd0) begin
        n_err++; $display("FAIL timeout_busy_%0d: en=%b thr=%0d, expected en=1 thr=0", k, f_enable, f_thread);
      end
    end
    @(negedge clk);
    n_vec++;
    if (f_enable !== 1'b0 || t_ack !== 4'b0001 || t_err !== 1'b1 || t_rdata !== '0) begin
      n_err++;
      $display("FAIL timeout_abort: en=%b ack=%b err=%b rd=%h, expected en=0 ack=0001 err=1 rd=0",
               f_enable, t_ack, t_err, t_rdata);
    end
    t_req = 4'b1000;
    @(negedge clk);
    n_vec++;
    if (f_enable !== 1'b0 || t_ack !== 4'b0000) begin
      n_err++; $display("FAIL timeout_gap: en=%b ack=%b, expected en=0 ack=0000", f_enable, t_ack);
    end
    @(negedge clk);
    n_vec++;
    if (f_enable !== 1'b1 || f_thread !== 2'd3 || f_addr !== 32'h300) begin
      n_err++;
      $display("FAIL timeout_next: en=%b thr=%0d addr=%h, expected en=1 thr=3 addr=00000300",
               f_enable, f_thread, f_addr);
    end
    f_ack = 1'b1;
    @(negedge clk);
    n_vec++;
    if (t_ack !== 4'b1000 || t_err !== 1'b0) begin
      n_err++; $display("FAIL timeout_next_ack: ack=%b err=%b, expected ack=1000 err=0", t_ack, t_err);
    end
    t_req = '0; f_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    t_req = 4'b0010;
    @(negedge clk);
    f_ack = 1'b1;
    @(negedge clk);
    t_req = '0; f_ack = 1'b0;
    @(negedge clk);
    t_req = 4'b1111;
    @(negedge clk);
    n_vec++;
    if (f_enable !== 1'b1 || f_thread !== 2'd2) begin
      n_err++; $display("FAIL midrst_pre_grant: en=%b thr=%0d, expected en=1 thr=2", f_enable, f_thread);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (f_enable !== 1'b0 || t_ack !== 4'b0000) begin
      n_err++; $display("FAIL midrst_abandon: en=%b ack=%b, expected en=0 ack=0000", f_enable, t_ack);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (f_enable !== 1'b1 || f_thread !== 2'd0 || t_ack !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst_regrant: en=%b thr=%0d ack=%b, expected en=1 thr=0 ack=0000",
               f_enable, f_thread, t_ack);
    end
    f_ack = 1'b1;
    @(negedge clk);
    n_vec++;
    if (t_ack !== 4'b0001) begin
      n_err++; $display("FAIL midrst_ack: t_ack=%b expected 0001", t_ack);
    end
    t_req = '0; f_ack = 1'b0;
    @(negedge clk);
  endtask

  // Reference tracks one transaction at a time: free -> transfer -> completion cycle.
  task automatic test_random();
    int ph, g, age, lat, m_last;
    int waits [4];
    logic [3:0]    p_req, exp_ack;
    logic          p_ack, exp_err, exp_w;
    logic [DW-1:0] p_rdata, exp_rd, exp_d;
    logic [AW-1:0] exp_a;
    apply_reset();
    ph = 0; g = 0; age = 0; lat = 1; m_last = 3;
    exp_err = 1'b0; exp_rd = '0; exp_w = 1'b0; exp_a = '0; exp_d = '0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    p_req = t_req; p_ack = f_ack; p_rdata = f_rdata;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      case (ph)
        0: if (p_req != 4'b0) begin
          g = pick(m_last, p_req);
          ph = 1; age = 1;
          exp_w = t_write[g]; exp_a = addr[g]; exp_d = wdat[g];
          case ($urandom_range(0, 5))
            0: lat = 1; 1: lat = 2; 2: lat = 3; 3: lat = 4; 4: lat = TO;
            default: lat = 100;
          endcase
          for (int i = 0; i < 4; i++) if (i != g && p_req[i]) begin
            waits[i]++;
            n_vec++;
            if (waits[i] > 3) begin
              n_err++; $display("FAIL rand_fairness: thread %0d passed over %0d times, limit 3", i, waits[i]);
            end
          end
          waits[g] = 0;
        end
        1: if (p_ack) begin
          ph = 2; exp_err = 1'b0; exp_rd = exp_w ? '0 : p_rdata; m_last = g;
        end else if (age == TO) begin
          ph = 2; exp_err = 1'b1; exp_rd = '0; m_last = g;
        end else age++;
        default: ph = 0;
      endcase
      exp_ack = (ph == 2) ? (4'b0001 << g) : 4'b0000;
      n_vec++;
      if (f_enable !== (ph == 1) || t_ack !== exp_ack) begin
        n_err++;
        $display("FAIL rand_ctrl cycle %0d: en=%b ack=%b, expected en=%b ack=%b",
                 c, f_enable, t_ack, ph == 1, exp_ack);
      end
      if (ph == 1) begin
        n_vec++;
        if (f_thread !== 2'(g) || f_addr !== exp_a || f_wdata !== exp_d || f_write !== exp_w) begin
          n_err++;
          $display("FAIL rand_fetch cycle %0d: thr=%0d addr=%h wd=%h wr=%b, expected thr=%0d addr=%h wd=%h wr=%b",
                   c, f_thread, f_addr, f_wdata, f_write, g, exp_a, exp_d, exp_w);
        end
      end
      if (ph == 2) begin
        n_vec++;
        if (t_err !== exp_err || t_rdata !== exp_rd) begin
          n_err++;
          $display("FAIL rand_resp cycle %0d: err=%b rd=%h, expected err=%b rd=%h",
                   c, t_err, t_rdata, exp_err, exp_rd);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (ph == 2 && g == i) t_req[i] = 1'b0;
        else if (!t_req[i] && $urandom_range(0, 2) == 0) begin
          addr[i] = $urandom; wdat[i] = $urandom;
          t_write[i] = 1'($urandom_range(0, 1));
          t_req[i] = 1'b1;
        end
      end
      f_ack   = (ph == 1) ? (age >= lat) : ($urandom_range(0, 3) == 0);
      f_rdata = $urandom;
      p_req = t_req; p_ack = f_ack; p_rdata = f_rdata;
    end
    t_req = '0; f_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; t_req = '0; t_write = '0; f_ack = 1'b0; f_rdata = '0;
    for (int i = 0; i < 4; i++) begin addr[i] = '0; wdat[i] = '0; end
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
